reg_writeback_unit: RTL

// - Writeback stage directly upstream of the 16x16 register file. Collects results from the ALU
//   and the memory unit, buffers them in order, and drives the file's single write port
//   (w_flag / write_code / w_data) with one write per clock.
// - Also forwards still-pending results to the operand-read stage, so reads never see stale data.

---
 rtl/reg_wb_pkg.sv | 22 ++
 rtl/wb_fifo_2in1out.sv | 77 +++++++
 rtl/reg_writeback_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register writeback unit.
package reg_wb_pkg;

  // Width of one result and of one register in the file.
  localparam int DATA_W  = 16;
  // Register index width (16 registers).
  localparam int ADDR_W  = 4;
  // Width of the register file's write-index port.
  localparam int WCODE_W = 16;

  // One pending register write: destination index plus result.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // The register file takes a 16-bit index; the upper bits are always zero.
  function automatic logic [WCODE_W-1:0] wb_write_code(input logic [ADDR_W-1:0] dest);
    return WCODE_W'(dest);
  endfunction

endpackage

// File: rtl/wb_fifo_2in1out.sv
// Circular writeback buffer: up to two pushes and one pop per clock.
// Push A is always older than push B when both occur in the same cycle.
// The caller guarantees there is room for every push it issues.
module wb_fifo_2in1out
  import reg_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        i_push_a,
  input  wb_entry_t                   i_entry_a,
  input  logic                        i_push_b,
  input  wb_entry_t                   i_entry_b,
  input  logic                        i_pop,
  output wb_entry_t                   o_head,
  output logic      [CNT_W-1:0]       o_count,
  output wb_entry_t [DEPTH-1:0]       o_entries,
  output logic      [DEPTH-1:0]       o_entry_vld
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_pop;
  logic [1:0]       w_n_push;
  logic [PTR_W-1:0] w_slot_b;

  // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Pop only when something is there; push count is 0..2.
  always_comb begin
    w_pop    = i_pop && (r_count != '0);
    w_n_push = {1'b0, i_push_a} + {1'b0, i_push_b};
    w_slot_b = i_push_a ? ptr_add(r_tail, 1) : r_tail;
  end

  // Entry storage: A lands at the tail, B right behind it (or at the tail alone).
  always_ff @(posedge clock) begin
    if (i_push_a) r_mem[r_tail]   <= i_entry_a;
    if (i_push_b) r_mem[w_slot_b] <= i_entry_b;
  end

  // Pointers and occupancy; reset empties the buffer and discards pending writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= ptr_add(r_head, 1);
      r_tail  <= ptr_add(r_tail, int'(w_n_push));
      r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
    end
  end

  // Oldest-first view of the buffer with a valid mask for the live entries.
  always_comb begin
    o_head  = r_mem[r_head];
    o_count = r_count;
    for (int k = 0; k < DEPTH; k++) begin
      o_entries[k]   = r_mem[ptr_add(r_head, k)];
      o_entry_vld[k] = (k < int'(r_count));
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage in front of the 16x16 register file: buffers ALU and load
// results in order, writes one per clock, and forwards pending results to
// the operand-read stage.
//
// Producer handshake: alu_valid / mem_valid are sampled at the rising edge.
// A result is taken only if in_ready is high in that cycle; in_ready never
// depends on the valids. A result offered while in_ready is low is dropped
// and sets the sticky overflow_err.
module reg_writeback_unit
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              in_ready,
  output logic              w_flag,
  output logic [WCODE_W-1:0] write_code,
  output logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              overflow_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t              w_alu_entry;
  wb_entry_t              w_mem_entry;
  wb_entry_t              w_head;
  wb_entry_t [DEPTH-1:0]  w_entries;
  logic      [DEPTH-1:0]  w_entry_vld;
  logic      [CNT_W-1:0]  w_count;
  logic                   w_push_alu;
  logic                   w_push_mem;
  logic                   w_nonempty;
  logic                   r_overflow;

  // Accept only when two free slots remain, so a dual offer always fits.
  always_comb begin
    in_ready    = (int'(w_count) + 2) <= DEPTH;
    w_push_alu  = alu_valid && in_ready;
    w_push_mem  = mem_valid && in_ready;
    w_alu_entry = '{dest: alu_dest, data: alu_data};
    w_mem_entry = '{dest: mem_dest, data: mem_data};
    w_nonempty  = (w_count != '0);
  end

  wb_fifo_2in1out #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_push_a    (w_push_alu),
    .i_entry_a   (w_alu_entry),
    .i_push_b    (w_push_mem),
    .i_entry_b   (w_mem_entry),
    .i_pop       (w_nonempty),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_entries   (w_entries),
    .o_entry_vld (w_entry_vld)
  );

  // Register-file write port: head entry whenever the buffer is non-empty, else zeros.
  always_comb begin
    w_flag     = w_nonempty;
    write_code = w_nonempty ? wb_write_code(w_head.dest) : '0;
    w_data     = w_nonempty ? w_head.data : '0;
  end

  // Sticky drop indicator; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if ((alu_valid || mem_valid) && !in_ready) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_err = r_overflow;

  // Forwarding: scan oldest to youngest so the youngest match wins; head included.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_entry_vld[k] && (w_entries[k].dest == rd_addr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = w_entries[k].data;
      end
      if (w_entry_vld[k] && (w_entries[k].dest == rd_addr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = w_entries[k].data;
      end
    end
  end

endmodule
